// File: rtl/matmul_out_pkg.sv
// Shared types and sizing helpers for the matmul output back-end.
package matmul_out_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    WAIT    = 2'd2,
    DONE    = 2'd3
  } out_state_e;

  // Elements that fit in one memory word.
  function automatic int calc_epw(input int mem_w, input int word_w);
    return mem_w / word_w;
  endfunction

  // Memory words needed to hold the whole matrix (last word may be partial).
  function automatic int calc_nwords(input int rows, input int cols, input int mem_w, input int word_w);
    int epw;
    epw = mem_w / word_w;
    return (rows * cols + epw - 1) / epw;
  endfunction

endpackage

// File: rtl/out_word_packer.sv
// Combinational row-major packer: selects memory word idx_i from the flattened result matrix,
// zero-filling lanes past the last element.
module out_word_packer
  import matmul_out_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int WORD_SIZE      = 16,
  parameter int MEM_PORT_WIDTH = 64,
  parameter int IDXW           = 2
) (
  input  logic [ROWS*COLS*WORD_SIZE-1:0] mat_i,
  input  logic [IDXW-1:0]                idx_i,
  output logic [MEM_PORT_WIDTH-1:0]      word_o
);

  localparam int NELEM  = ROWS * COLS;
  localparam int EPW    = calc_epw(MEM_PORT_WIDTH, WORD_SIZE);
  localparam int NWORDS = calc_nwords(ROWS, COLS, MEM_PORT_WIDTH, WORD_SIZE);
  localparam int PADW   = NWORDS * MEM_PORT_WIDTH;

  logic [PADW-1:0] padded;

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS * EPW; gi++) begin : g_lane
      if (gi < NELEM) begin : g_elem
        assign padded[gi*WORD_SIZE +: WORD_SIZE] = mat_i[gi*WORD_SIZE +: WORD_SIZE];
      end else begin : g_pad
        assign padded[gi*WORD_SIZE +: WORD_SIZE] = '0;
      end
    end
  endgenerate

  assign word_o = padded[int'(idx_i)*MEM_PORT_WIDTH +: MEM_PORT_WIDTH];

endmodule

// File: rtl/matmul_output_ctrl.sv
// Output back-end of the systolic matmul: captures per-column results into a ROWS x COLS buffer,
// then writes it row-major to the output RAM. Optional WPROXY_EN adds proxy ports that override columns.
module matmul_output_ctrl
  import matmul_out_pkg::*;
#(
  parameter int ROWS               = 4,
  parameter int COLS               = 4,
  parameter int WORD_SIZE          = 16,
  parameter int MEM_PORT_WIDTH     = 64,
  parameter int MEM_ACCESS_LATENCY = 1,
  parameter int OUT_BASE_ADDR      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fsm_rdy,
  input  logic                          fsm_done,
  input  logic [COLS*WORD_SIZE-1:0]     matmul_fsm_output,
  input  logic [COLS-1:0]               matmul_output_valid,
`ifdef WPROXY_EN
  input  logic [COLS*WORD_SIZE-1:0]     proxy_output_bus,
  input  logic [COLS-1:0]               proxy_out_valid_bus,
`endif
  output logic                          stall,
  output logic                          wr_output_rdy,
  output logic                          wr_output_done,
  output logic [31:0]                   mem_addr,
  output logic                          mem_wr_en,
  output logic [MEM_PORT_WIDTH-1:0]     mem_data
);

  localparam int NELEM  = ROWS * COLS;
  localparam int NWORDS = calc_nwords(ROWS, COLS, MEM_PORT_WIDTH, WORD_SIZE);
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CNTW   = $clog2(ROWS + 1);
  localparam int LATW   = (MEM_ACCESS_LATENCY > 0) ? $clog2(MEM_ACCESS_LATENCY + 1) : 1;

  out_state_e                     state_q;
  logic [CNTW-1:0]                row_cnt_q [COLS];
  logic [CNTW-1:0]                row_cnt_d [COLS];
  logic [NELEM*WORD_SIZE-1:0]     mat_q, mat_d;
  logic [IDXW-1:0]                idx_q, widx;
  logic [LATW-1:0]                wait_q;
  logic                           rdy_q, done_pend_q, stall_q, wr_en_q, done_q;
  logic [31:0]                    addr_q;
  logic [MEM_PORT_WIDTH-1:0]      data_q, word_next;

  logic [COLS-1:0]                col_valid, col_full, col_full_d;
  logic [WORD_SIZE-1:0]           col_data [COLS];
  logic                           full_q, full_d, go, last_word;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
`ifdef WPROXY_EN
      // Proxy repairs a faulty column, so it wins over the array's own result.
      assign col_valid[gi] = proxy_out_valid_bus[gi] | matmul_output_valid[gi];
      assign col_data[gi]  = proxy_out_valid_bus[gi] ? proxy_output_bus[gi*WORD_SIZE +: WORD_SIZE]
                                                     : matmul_fsm_output[gi*WORD_SIZE +: WORD_SIZE];
`else
      assign col_valid[gi] = matmul_output_valid[gi];
      assign col_data[gi]  = matmul_fsm_output[gi*WORD_SIZE +: WORD_SIZE];
`endif
      assign col_full[gi]   = (row_cnt_q[gi] == CNTW'(ROWS));
      assign col_full_d[gi] = (row_cnt_d[gi] == CNTW'(ROWS));
    end
  endgenerate

  assign full_q = &col_full;
  assign full_d = &col_full_d;

  always_comb begin
    mat_d     = mat_q;
    row_cnt_d = row_cnt_q;
    if (state_q == COLLECT) begin
      if (fsm_rdy && !full_q) begin
        for (int c = 0; c < COLS; c++) row_cnt_d[c] = '0;
      end else begin
        for (int c = 0; c < COLS; c++) begin
          if (col_valid[c] && !col_full[c]) begin
            mat_d[(int'(row_cnt_q[c]) * COLS + c) * WORD_SIZE +: WORD_SIZE] = col_data[c];
            row_cnt_d[c] = row_cnt_q[c] + CNTW'(1);
          end
        end
      end
    end else if (state_q == DONE) begin
      for (int c = 0; c < COLS; c++) row_cnt_d[c] = '0;
    end
  end

  assign last_word = (idx_q == IDXW'(NWORDS - 1));
  assign go        = (state_q == COLLECT) && full_d && (fsm_done || done_pend_q);

  // Index of the word the next write strobe will carry.
  always_comb begin
    widx = '0;
    if (state_q != COLLECT && !last_word) widx = idx_q + IDXW'(1);
  end

  out_word_packer #(
    .ROWS           (ROWS),
    .COLS           (COLS),
    .WORD_SIZE      (WORD_SIZE),
    .MEM_PORT_WIDTH (MEM_PORT_WIDTH),
    .IDXW           (IDXW)
  ) u_packer (
    .mat_i  (mat_d),
    .idx_i  (widx),
    .word_o (word_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      mat_q       <= '0;
      for (int c = 0; c < COLS; c++) row_cnt_q[c] <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      rdy_q       <= 1'b0;
      done_pend_q <= 1'b0;
      stall_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      mat_q     <= mat_d;
      row_cnt_q <= row_cnt_d;
      rdy_q     <= full_d;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (fsm_done) done_pend_q <= 1'b1;
          if (go) begin
            state_q     <= WRITE;
            done_pend_q <= 1'b0;
            stall_q     <= 1'b1;
            idx_q       <= '0;
            wr_en_q     <= 1'b1;
            addr_q      <= 32'(OUT_BASE_ADDR) + 32'(widx);
            data_q      <= word_next;
          end
        end
        WRITE: begin
          if (MEM_ACCESS_LATENCY > 0) begin
            state_q <= WAIT;
            wait_q  <= '0;
          end else if (last_word) begin
            state_q <= DONE;
            stall_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= widx;
            wr_en_q <= 1'b1;
            addr_q  <= 32'(OUT_BASE_ADDR) + 32'(widx);
            data_q  <= word_next;
          end
        end
        WAIT: begin
          if (int'(wait_q) == MEM_ACCESS_LATENCY - 1) begin
            if (last_word) begin
              state_q <= DONE;
              stall_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= WRITE;
              idx_q   <= widx;
              wr_en_q <= 1'b1;
              addr_q  <= 32'(OUT_BASE_ADDR) + 32'(widx);
              data_q  <= word_next;
            end
          end else begin
            wait_q <= wait_q + LATW'(1);
          end
        end
        DONE: begin
          state_q <= COLLECT;
          idx_q   <= '0;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign stall          = stall_q;
  assign wr_output_rdy  = rdy_q;
  assign wr_output_done = done_q;
  assign mem_addr       = addr_q;
  assign mem_wr_en      = wr_en_q;
  assign mem_data       = data_q;

endmodule

// File: tb/tb_matmul_output_ctrl.sv
// Directed bench for matmul_output_ctrl: a latency-1 and a latency-3 instance share all inputs.
// Build with WPROXY_EN defined to exercise the proxy override.
module tb_matmul_output_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fsm_rdy = 1'b0;
  logic        fsm_done = 1'b0;
  logic [63:0] mout = '0;
  logic [3:0]  mvalid = '0;
`ifdef WPROXY_EN
  logic [63:0] pdata = '0;
  logic [3:0]  pvalid = '0;
`endif

  logic        a_stall, a_rdy, a_done, a_wr;
  logic [31:0] a_addr;
  logic [63:0] a_data;
  logic        b_stall, b_rdy, b_done, b_wr;
  logic [31:0] b_addr;
  logic [63:0] b_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_word [4];
  logic [31:0] wa_addr [8];
  logic [63:0] wa_data [8];
  int          wa_cyc  [8];
  logic [63:0] wb_data [8];
  int          wb_cyc  [8];
  int          na, nb, da, db, stall_bad;

  always #5 clk = ~clk;

  matmul_output_ctrl #(
    .ROWS(4), .COLS(4), .WORD_SIZE(16), .MEM_PORT_WIDTH(64),
    .MEM_ACCESS_LATENCY(1), .OUT_BASE_ADDR(0)
  ) u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .fsm_rdy             (fsm_rdy),
    .fsm_done            (fsm_done),
    .matmul_fsm_output   (mout),
    .matmul_output_valid (mvalid),
`ifdef WPROXY_EN
    .proxy_output_bus    (pdata),
    .proxy_out_valid_bus (pvalid),
`endif
    .stall               (a_stall),
    .wr_output_rdy       (a_rdy),
    .wr_output_done      (a_done),
    .mem_addr            (a_addr),
    .mem_wr_en           (a_wr),
    .mem_data            (a_data)
  );

  matmul_output_ctrl #(
    .ROWS(4), .COLS(4), .WORD_SIZE(16), .MEM_PORT_WIDTH(64),
    .MEM_ACCESS_LATENCY(3), .OUT_BASE_ADDR(0)
  ) u_dut_l3 (
    .clk                 (clk),
    .rst                 (rst),
    .fsm_rdy             (fsm_rdy),
    .fsm_done            (fsm_done),
    .matmul_fsm_output   (mout),
    .matmul_output_valid (mvalid),
`ifdef WPROXY_EN
    .proxy_output_bus    (pdata),
    .proxy_out_valid_bus (pvalid),
`endif
    .stall               (b_stall),
    .wr_output_rdy       (b_rdy),
    .wr_output_done      (b_done),
    .mem_addr            (b_addr),
    .mem_wr_en           (b_wr),
    .mem_data            (b_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Element (r,c) is r*4+c+1; element (0,2) can be overridden.
  task automatic set_exp(input logic [15:0] c2r0);
    for (int w = 0; w < 4; w++) begin
      for (int l = 0; l < 4; l++) begin
        int k;
        k = w * 4 + l;
        exp_word[w][16*l +: 16] = (k == 2) ? c2r0 : 16'(k + 1);
      end
    end
  endtask

  // Stream the 4x4 matrix; with skew, column c runs on cycles c..c+3.
  task automatic fill(input bit skew, input logic [15:0] c2r0, input bit use_proxy, input int done_at);
    int ncyc;
    ncyc = skew ? 7 : 4;
    for (int cy = 0; cy < ncyc; cy++) begin
      mvalid = '0;
      mout   = '0;
`ifdef WPROXY_EN
      pvalid = '0;
      pdata  = '0;
`endif
      for (int c = 0; c < 4; c++) begin
        int r;
        r = skew ? cy - c : cy;
        if (r >= 0 && r < 4) begin
          mvalid[c] = 1'b1;
          mout[c*16 +: 16] = (r == 0 && c == 2) ? c2r0 : 16'(r * 4 + c + 1);
`ifdef WPROXY_EN
          if (use_proxy && r == 0 && c == 2) begin
            pvalid[c] = 1'b1;
            pdata[c*16 +: 16] = 16'hBEEF;
          end
`endif
        end
      end
      if (use_proxy) ; // proxy request is meaningful only with the proxy ports present
      fsm_done = (cy == done_at);
      @(negedge clk);
    end
    mvalid   = '0;
    fsm_done = 1'b0;
`ifdef WPROXY_EN
    pvalid = '0;
`endif
  endtask

  // Observe both instances for up to max_cyc cycles, one observation per negedge.
  task automatic collect(input int max_cyc, input int stop_na);
    na = 0; nb = 0; da = 0; db = 0; stall_bad = 0;
    for (int i = 0; i < 8; i++) begin
      wa_addr[i] = '1; wa_data[i] = '1; wa_cyc[i] = -100;
      wb_data[i] = '1; wb_cyc[i] = -100;
    end
    for (int i = 0; i < max_cyc; i++) begin
      if (a_wr) begin
        $display("[%0t] lat1 write addr=%0d data=%h", $time, a_addr, a_data);
        if (na < 8) begin wa_addr[na] = a_addr; wa_data[na] = a_data; wa_cyc[na] = i; end
        na++;
      end
      if (na > 0 && da == 0 && !a_done && !a_stall) stall_bad++;
      if (a_done) begin
        $display("[%0t] lat1 done", $time);
        da++;
        if (a_stall) stall_bad++;
      end
      if (b_wr) begin
        $display("[%0t] lat3 write addr=%0d data=%h", $time, b_addr, b_data);
        if (nb < 8) begin wb_data[nb] = b_data; wb_cyc[nb] = i; end
        nb++;
      end
      if (nb > 0 && db == 0 && !b_done && !b_stall) stall_bad++;
      if (b_done) begin
        $display("[%0t] lat3 done", $time);
        db++;
      end
      if (stop_na > 0 && na >= stop_na) return;
      @(negedge clk);
    end
  endtask

  task automatic check_wb(input string tag);
    check({tag, "_nwrites"}, 64'(na), 64'd4);
    check({tag, "_nwrites_l3"}, 64'(nb), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(wa_addr[i]), 64'(i));
      check($sformatf("%s_data%0d", tag, i), wa_data[i], exp_word[i]);
      check($sformatf("%s_data%0d_l3", tag, i), wb_data[i], exp_word[i]);
    end
    for (int i = 1; i < 4; i++) begin
      check($sformatf("%s_gap%0d", tag, i), 64'(wa_cyc[i] - wa_cyc[i-1]), 64'd2);
      check($sformatf("%s_gap%0d_l3", tag, i), 64'(wb_cyc[i] - wb_cyc[i-1]), 64'd4);
    end
    check({tag, "_done_pulses"}, 64'(da), 64'd1);
    check({tag, "_done_pulses_l3"}, 64'(db), 64'd1);
    check({tag, "_stall"}, 64'(stall_bad), 64'd0);
    check({tag, "_rdy_after"}, {62'd0, a_rdy, b_rdy}, 64'd0);
  endtask

  initial begin
    int ev;
    // Reset
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_stall", 64'(a_stall), 64'd0);
    check("rst_rdy", 64'(a_rdy), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_wr_en", 64'(a_wr), 64'd0);
    check("rst_addr", 64'(a_addr), 64'd0);
    check("rst_data", a_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fill: aligned columns, done held back until after rdy is seen
    set_exp(16'd3);
    check("word0_const", exp_word[0], 64'h0004_0003_0002_0001);
    fill(1'b0, 16'd3, 1'b0, -1);
    mvalid = 4'hF;
    mout   = {4{16'hFFFF}};
    check("fill_rdy", 64'(a_rdy), 64'd1);
    check("fill_wait_no_wr", 64'(a_wr), 64'd0);
    @(negedge clk);
    mvalid   = '0;
    fsm_done = 1'b1;
    @(negedge clk);
    fsm_done = 1'b0;
    collect(40, 0);
    check_wb("fill");

    // Skew: partial junk discarded by fsm_rdy, then skewed stream with early fsm_done
    mvalid = 4'hF;
    mout   = {4{16'hAAAA}};
    @(negedge clk);
    @(negedge clk);
    mvalid  = '0;
    fsm_rdy = 1'b1;
    @(negedge clk);
    fsm_rdy = 1'b0;
    check("partial_rdy", 64'(a_rdy), 64'd0);
    fill(1'b1, 16'd3, 1'b0, 0);
    collect(40, 0);
    check_wb("skew");

    // Proxy override on column 2, fsm_done together with the last store
`ifdef WPROXY_EN
    set_exp(16'hBEEF);
`else
    set_exp(16'hDEAD);
`endif
    fill(1'b0, 16'hDEAD, 1'b1, 3);
    collect(40, 0);
    check_wb("proxy");

    // Reset during write-back, right after the second write
    set_exp(16'd3);
    fill(1'b0, 16'd3, 1'b0, 3);
    collect(30, 2);
    check("midrst_reached", 64'(na), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wr_en", 64'(a_wr), 64'd0);
    check("midrst_stall", 64'(a_stall), 64'd0);
    check("midrst_rdy", 64'(a_rdy), 64'd0);
    check("midrst_stall_l3", 64'(b_stall), 64'd0);
    rst = 1'b0;
    ev = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_wr || a_done || b_wr || b_done) ev++;
      @(negedge clk);
    end
    check("midrst_quiet", 64'(ev), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
